// File: rtl/clock_display_scan_if.sv
// rtl/clock_display_scan_if.sv - counter inputs and seven-segment outputs of the display scanner
interface clock_display_scan_if;
   logic [3:0] hours;
   logic [5:0] minutes;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;
   logic       frame_start;

   modport master (output hours, minutes, input an, seg, dp, frame_start);
   modport slave  (input hours, minutes, output an, seg, dp, frame_start);
endinterface

// File: rtl/clock_display_scan.sv
// rtl/clock_display_scan.sv - HH.MM four-digit seven-segment scanner with per-frame input latch
// Optional feature macro: LEADING_ZERO_BLANK_EN (dark hours-tens digit when it is zero)
module clock_display_scan #(
   parameter int CLK_HZ       = 100_000_000,
   parameter int REFRESH_HZ   = 1000,
   parameter bit COMMON_ANODE = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   clock_display_scan_if.slave   bus
);
   localparam int             DIV      = CLK_HZ / REFRESH_HZ;
   localparam int             CW       = $clog2(DIV);
   localparam logic [CW-1:0]  DIV_LAST = CW'(DIV - 1);

   logic [3:0]    h_s1_q, h_s1_d, h_s2_q, h_s2_d;
   logic [5:0]    m_s1_q, m_s1_d, m_s2_q, m_s2_d;
   logic [CW-1:0] div_ctr_q, div_ctr_d;
   logic [1:0]    digit_q, digit_d;
   logic [3:0]    shadow_h_q, shadow_h_d;
   logic [5:0]    shadow_m_q, shadow_m_d;
   logic          frame_start_q, frame_start_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic          dp_q, dp_d;

   logic          tick, latch, ht, valid, dp_int;
   logic [3:0]    ho, mt, mo, cur, an_int;
   logic [5:0]    m_sub;
   logic [6:0]    seg_int;

   function automatic logic [6:0] font(input logic [3:0] v);
      case (v)
         4'd0:    font = 7'h3F;
         4'd1:    font = 7'h06;
         4'd2:    font = 7'h5B;
         4'd3:    font = 7'h4F;
         4'd4:    font = 7'h66;
         4'd5:    font = 7'h6D;
         4'd6:    font = 7'h7D;
         4'd7:    font = 7'h07;
         4'd8:    font = 7'h7F;
         4'd9:    font = 7'h6F;
         default: font = 7'h00;
      endcase
   endfunction

   always_comb begin
      h_s1_d = bus.hours;
      h_s2_d = h_s1_q;
      m_s1_d = bus.minutes;
      m_s2_d = m_s1_q;

      tick      = (div_ctr_q == DIV_LAST);
      div_ctr_d = tick ? '0 : div_ctr_q + 1'b1;
      digit_d   = tick ? digit_q + 2'd1 : digit_q;

      // Shadow reload only at the end of slot 3 so a whole frame shows one consistent time
      latch         = tick && (digit_q == 2'd3);
      shadow_h_d    = latch ? h_s2_q : shadow_h_q;
      shadow_m_d    = latch ? m_s2_q : shadow_m_q;
      frame_start_d = latch;

      ht = (shadow_h_q >= 4'd10);
      ho = ht ? shadow_h_q - 4'd10 : shadow_h_q;

      if      (shadow_m_q >= 6'd50) begin mt = 4'd5; m_sub = 6'd50; end
      else if (shadow_m_q >= 6'd40) begin mt = 4'd4; m_sub = 6'd40; end
      else if (shadow_m_q >= 6'd30) begin mt = 4'd3; m_sub = 6'd30; end
      else if (shadow_m_q >= 6'd20) begin mt = 4'd2; m_sub = 6'd20; end
      else if (shadow_m_q >= 6'd10) begin mt = 4'd1; m_sub = 6'd10; end
      else                          begin mt = 4'd0; m_sub = 6'd0;  end
      mo = 4'(shadow_m_q - m_sub);

      valid = (shadow_h_q != 4'd0) && (shadow_h_q <= 4'd12) && (shadow_m_q <= 6'd59);

      case (digit_q)
         2'd0:    cur = mo;
         2'd1:    cur = mt;
         2'd2:    cur = ho;
         default: cur = {3'b000, ht};
      endcase

      seg_int = valid ? font(cur) : 7'h40;
      dp_int  = valid && (digit_q == 2'd2);
      an_int  = 4'b0001 << digit_q;
`ifdef LEADING_ZERO_BLANK_EN
      if (valid && (digit_q == 2'd3) && !ht)
         an_int = 4'b0000;
`else
`endif

      an_d  = an_int  ^ {4{COMMON_ANODE}};
      seg_d = seg_int ^ {7{COMMON_ANODE}};
      dp_d  = dp_int  ^ COMMON_ANODE;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         h_s1_q        <= '0;
         h_s2_q        <= '0;
         m_s1_q        <= '0;
         m_s2_q        <= '0;
         div_ctr_q     <= '0;
         digit_q       <= '0;
         shadow_h_q    <= 4'd12;
         shadow_m_q    <= 6'd0;
         frame_start_q <= 1'b0;
         an_q          <= {4{COMMON_ANODE}};
         seg_q         <= {7{COMMON_ANODE}};
         dp_q          <= COMMON_ANODE;
      end else begin
         h_s1_q        <= h_s1_d;
         h_s2_q        <= h_s2_d;
         m_s1_q        <= m_s1_d;
         m_s2_q        <= m_s2_d;
         div_ctr_q     <= div_ctr_d;
         digit_q       <= digit_d;
         shadow_h_q    <= shadow_h_d;
         shadow_m_q    <= shadow_m_d;
         frame_start_q <= frame_start_d;
         an_q          <= an_d;
         seg_q         <= seg_d;
         dp_q          <= dp_d;
      end
   end

   assign bus.an          = an_q;
   assign bus.seg         = seg_q;
   assign bus.dp          = dp_q;
   assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_clock_display_scan.sv
// tb/tb_clock_display_scan.sv - randomized bench with time-based display model for clock_display_scan
module tb_clock_display_scan;
   localparam int DIV   = 4;
   localparam int FRAME = 4 * DIV;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   clock_display_scan_if dif();

   clock_display_scan #(.CLK_HZ(16), .REFRESH_HZ(4), .COMMON_ANODE(1'b1)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (dif.slave)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Display model: slot and latch timing from the edge count since reset, digits by div/mod
   logic [6:0] font_tbl [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
   bit   model_ok = 0;
   int   k, sh, sm, p1h, p1m, p2h, p2m;
   logic [3:0] e_an;
   logic [6:0] e_seg;
   logic e_dp, e_fs;
   bit   e_seg_care;

   always @(posedge clk) begin : model
      int  slot, dval;
      bit  valid;
      if (!reset_n) begin
         model_ok = 1; k = 0; sh = 12; sm = 0;
         p1h = 0; p1m = 0; p2h = 0; p2m = 0;
         e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0; e_seg_care = 1;
      end else if (model_ok) begin
         slot  = (k / DIV) % 4;
         valid = (sh >= 1) && (sh <= 12) && (sm <= 59);
         case (slot)
            0:       dval = sm % 10;
            1:       dval = sm / 10;
            2:       dval = sh % 10;
            default: dval = sh / 10;
         endcase
         e_seg      = ~(valid ? font_tbl[dval] : 7'h40);
         e_dp       = !(valid && slot == 2);
         e_an       = ~4'(1 << slot);
         e_seg_care = 1;
`ifdef LEADING_ZERO_BLANK_EN
         if (valid && slot == 3 && sh < 10) begin
            e_an = 4'hF;
            e_seg_care = 0;
         end
`else
`endif
         k++;
         e_fs = ((k % FRAME) == 0);
         if (e_fs) begin
            sh = p2h;
            sm = p2m;
         end
         p2h = p1h; p2m = p1m;
         p1h = int'(dif.hours); p1m = int'(dif.minutes);
      end
   end

   always @(negedge clk) begin
      if (model_ok) begin
         chk("m_an", dif.an, e_an);
         if (e_seg_care) chk("m_seg", dif.seg, e_seg);
         chk("m_dp", dif.dp, e_dp);
         chk("m_fs", dif.frame_start, e_fs);
      end
   end

   task automatic wait_fs();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!dif.frame_start && n < 100);
      chk("fs_wait", dif.frame_start, 1'b1);
   endtask

   // Called at the negedge showing frame_start; walks the four slots of the new frame
   task automatic check_frame(input string name, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic dp2, input logic [3:0] an3);
      @(negedge clk);
      chk({name, "_an0"}, dif.an, 4'b1110);
      chk({name, "_s0"}, dif.seg, s0);
      chk({name, "_dp0"}, dif.dp, 1'b1);
      repeat (DIV) @(negedge clk);
      chk({name, "_an1"}, dif.an, 4'b1101);
      chk({name, "_s1"}, dif.seg, s1);
      repeat (DIV) @(negedge clk);
      chk({name, "_an2"}, dif.an, 4'b1011);
      chk({name, "_s2"}, dif.seg, s2);
      chk({name, "_dp2"}, dif.dp, dp2);
      repeat (DIV) @(negedge clk);
      chk({name, "_an3"}, dif.an, an3);
      if (an3 != 4'hF) chk({name, "_s3"}, dif.seg, s3);
   endtask

   logic [3:0] an3_lz;
   logic [6:0] lz_seg;

   initial begin
      dif.hours = 4'd12;
      dif.minutes = 6'd0;
`ifdef LEADING_ZERO_BLANK_EN
      an3_lz = 4'hF; lz_seg = 7'h7F;
`else
      an3_lz = 4'b0111; lz_seg = 7'h40;
`endif
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_an", dif.an, 4'hF);
      chk("rst_seg", dif.seg, 7'h7F);
      chk("rst_dp", dif.dp, 1'b1);
      chk("rst_fs", dif.frame_start, 1'b0);
      reset_n = 1'b1;

      @(negedge clk);
      chk("walk0", dif.an, 4'b1110);
      repeat (DIV) @(negedge clk);
      chk("walk1", dif.an, 4'b1101);
      repeat (DIV) @(negedge clk);
      chk("walk2", dif.an, 4'b1011);
      repeat (DIV) @(negedge clk);
      chk("walk3", dif.an, 4'b0111);

      dif.hours = 4'd10; dif.minutes = 6'd37;
      wait_fs(); wait_fs();
      check_frame("t1037", 7'h78, 7'h30, 7'h40, 7'h79, 1'b0, 4'b0111);

      wait_fs();
      repeat (2) @(negedge clk);
      dif.minutes = 6'd38;
      @(negedge clk);
      chk("mid_frame_hold", dif.seg, 7'h78);
      wait_fs();
      @(negedge clk);
      chk("t1038_s0", dif.seg, 7'h00);

      dif.hours = 4'd13; dif.minutes = 6'd0;
      wait_fs(); wait_fs();
      check_frame("inv_h13", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b1, 4'b0111);
      dif.hours = 4'd5; dif.minutes = 6'd60;
      wait_fs(); wait_fs();
      check_frame("inv_m60", 7'h3F, 7'h3F, 7'h3F, 7'h3F, 1'b1, 4'b0111);
      dif.hours = 4'd1; dif.minutes = 6'd0;
      wait_fs(); wait_fs();
      check_frame("t0100", 7'h40, 7'h40, 7'h79, lz_seg, 1'b0, an3_lz);
      dif.hours = 4'd9; dif.minutes = 6'd5;
      wait_fs(); wait_fs();
      check_frame("t0905", 7'h12, 7'h40, 7'h10, lz_seg, 1'b0, an3_lz);

      wait_fs();
      @(negedge clk);
      repeat (2 * DIV) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_an", dif.an, 4'hF);
      chk("mid_rst_seg", dif.seg, 7'h7F);
      chk("mid_rst_dp", dif.dp, 1'b1);
      chk("mid_rst_fs", dif.frame_start, 1'b0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("r12_an0", dif.an, 4'b1110);
      chk("r12_s0", dif.seg, 7'h40);
      repeat (DIV) @(negedge clk);
      chk("r12_s1", dif.seg, 7'h40);
      repeat (DIV) @(negedge clk);
      chk("r12_s2", dif.seg, 7'h24);
      chk("r12_dp2", dif.dp, 1'b0);
      repeat (DIV) @(negedge clk);
      chk("r12_an3", dif.an, 4'b0111);
      chk("r12_s3", dif.seg, 7'h79);

      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(4, 0) != 0) begin
            dif.hours   = 4'($urandom_range(12, 1));
            dif.minutes = 6'($urandom_range(59, 0));
         end else begin
            dif.hours   = 4'($urandom_range(15, 0));
            dif.minutes = 6'($urandom_range(63, 0));
         end
         repeat ($urandom_range(60, 1)) @(negedge clk);
         if ($urandom_range(14, 0) == 0) begin
            reset_n = 1'b0;
            repeat ($urandom_range(3, 1)) @(negedge clk);
            reset_n = 1'b1;
         end
      end

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
